// File: rtl/ring_buffer.sv
// ring_buffer: single-clock FIFO on a circular memory with a registered head
// output, optional overwrite-oldest behaviour when full, and sticky overflow
// tracking with a saturating lost-entry counter.
//
// Ports
//   clock          in   rising-edge clock for all state
//   reset          in   asynchronous active-low reset
//   clear          in   synchronous flush (contents, level, overflow state)
//   write_enable   in   push write_data this cycle
//   write_data     in   DW-bit data to push
//   read_ready     in   consumer takes read_data this cycle
//   read_valid     out  read_data holds the oldest unread entry
//   read_data      out  oldest unread entry (registered)
//   empty          out  level == 0
//   full           out  level == DEPTH
//   level          out  unread entries, including the one on read_data
//   overflow       out  sticky: a full-condition write lost data
//   overflow_count out  number of lost entries, saturating at 16'hFFFF
module ring_buffer #(
  parameter int DW        = 8,
  parameter int AW        = 8,
  parameter int OVERWRITE = 0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          write_enable,
  input  logic [DW-1:0] write_data,
  input  logic          read_ready,
  output logic          read_valid,
  output logic [DW-1:0] read_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic [15:0]   overflow_count
);

  localparam int          DEPTH     = 1 << AW;
  localparam logic [AW:0] DEPTH_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [DW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          read_valid_q, read_valid_d;
  logic [DW-1:0] read_data_q, read_data_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   ovf_cnt_q, ovf_cnt_d;

  logic          is_full;
  logic          pop;
  logic          lost;
  logic          push_store;
  logic          advance;
  logic          mem_we;
  logic [AW:0]   kept;

  always_comb begin
    is_full    = (level_q == DEPTH_LVL);
    pop        = read_valid_q && read_ready;
    // A full-condition push without a pop always loses one entry: either the
    // new data (drop mode) or the oldest stored entry (overwrite mode).
    lost       = write_enable && is_full && !pop;
    push_store = write_enable && (!is_full || pop || (OVERWRITE != 0));
    advance    = pop || (lost && (OVERWRITE != 0));
    mem_we     = push_store && !clear;

    // Entries already in memory before this edge that survive it. Only these
    // may be presented after the edge, which enforces the one-cycle write to
    // read_valid latency without needing a write-through bypass.
    kept = advance ? (level_q - LVL_ONE) : level_q;

    wr_ptr_d     = push_store ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d     = advance    ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    level_d      = level_q;
    if (push_store && !advance) level_d = level_q + LVL_ONE;
    if (!push_store && advance) level_d = level_q - LVL_ONE;

    read_valid_d = (kept != '0);
    read_data_d  = read_valid_d ? mem_q[rd_ptr_d] : read_data_q;

    overflow_d   = overflow_q || lost;
    ovf_cnt_d    = ovf_cnt_q;
    if (lost && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_d = ovf_cnt_q + 16'd1;

    if (clear) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      level_d      = '0;
      read_valid_d = 1'b0;
      read_data_d  = read_data_q;
      overflow_d   = 1'b0;
      ovf_cnt_d    = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      read_valid_q <= 1'b0;
      read_data_q  <= '0;
      overflow_q   <= 1'b0;
      ovf_cnt_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      read_valid_q <= read_valid_d;
      read_data_q  <= read_data_d;
      overflow_q   <= overflow_d;
      ovf_cnt_q    <= ovf_cnt_d;
    end
  end

  // Storage has no reset; stale contents are unreachable once pointers reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[wr_ptr_q] <= write_data;
  end

  assign read_valid     = read_valid_q;
  assign read_data      = read_data_q;
  assign level          = level_q;
  assign empty          = (level_q == '0);
  assign full           = is_full;
  assign overflow       = overflow_q;
  assign overflow_count = ovf_cnt_q;

endmodule

// File: tb/tb_ring_buffer.sv
// Directed bench for ring_buffer: two AW=2 instances (drop mode and
// overwrite mode) share the same stimulus and are checked against
// hand-computed expectations.
module tb_ring_buffer;

  logic       clock = 1'b0;
  logic       reset;
  logic       clear;
  logic       we;
  logic [7:0] wd;
  logic       rr;

  logic       rv0, em0, fu0, ov0;
  logic [7:0] rd0;
  logic [2:0] lv0;
  logic [15:0] oc0;
  logic       rv1, em1, fu1, ov1;
  logic [7:0] rd1;
  logic [2:0] lv1;
  logic [15:0] oc1;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  ring_buffer #(.DW(8), .AW(2), .OVERWRITE(0)) u_drop (
    .clock(clock), .reset(reset), .clear(clear),
    .write_enable(we), .write_data(wd), .read_ready(rr),
    .read_valid(rv0), .read_data(rd0), .empty(em0), .full(fu0),
    .level(lv0), .overflow(ov0), .overflow_count(oc0)
  );

  ring_buffer #(.DW(8), .AW(2), .OVERWRITE(1)) u_ovwr (
    .clock(clock), .reset(reset), .clear(clear),
    .write_enable(we), .write_data(wd), .read_ready(rr),
    .read_valid(rv1), .read_data(rd1), .empty(em1), .full(fu1),
    .level(lv1), .overflow(ov1), .overflow_count(oc1)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; we = 1'b0; wd = 8'h00; rr = 1'b0;
    #1 reset = 1'b0;
    #2;
    checks++;
    if ({rv0, em0, fu0, lv0, ov0, oc0, rd0} !== {1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 16'd0, 8'd0}) begin
      errors++;
      $display("FAIL reset_drop got rv=%b em=%b fu=%b lv=%0d ov=%b oc=%0d rd=%h exp rv=0 em=1 fu=0 lv=0 ov=0 oc=0 rd=00",
               rv0, em0, fu0, lv0, ov0, oc0, rd0);
    end
    checks++;
    if ({rv1, em1, fu1, lv1, ov1, oc1, rd1} !== {1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 16'd0, 8'd0}) begin
      errors++;
      $display("FAIL reset_ovwr got rv=%b em=%b fu=%b lv=%0d ov=%b oc=%0d rd=%h exp rv=0 em=1 fu=0 lv=0 ov=0 oc=0 rd=00",
               rv1, em1, fu1, lv1, ov1, oc1, rd1);
    end
    #9 reset = 1'b1;   // released between clock edges
    step();
  endtask

  task automatic test_latency();
    we = 1'b1; wd = 8'hF1;
    step();
    we = 1'b0;
    checks++;
    if ({lv0, rv0} !== {3'd1, 1'b0}) begin
      errors++; $display("FAIL lat_no_bypass got lv=%0d rv=%b exp lv=1 rv=0", lv0, rv0);
    end
    step();
    checks++;
    if ({rv0, rd0, lv0, em0} !== {1'b1, 8'hF1, 3'd1, 1'b0}) begin
      errors++; $display("FAIL lat_first got rv=%b rd=%h lv=%0d em=%b exp rv=1 rd=f1 lv=1 em=0", rv0, rd0, lv0, em0);
    end
    step(); step();
    checks++;
    if ({rv1, rd1, lv1} !== {1'b1, 8'hF1, 3'd1}) begin
      errors++; $display("FAIL lat_hold got rv=%b rd=%h lv=%0d exp rv=1 rd=f1 lv=1", rv1, rd1, lv1);
    end
    rr = 1'b1;
    step();
    checks++;
    if ({em0, rv0, lv0} !== {1'b1, 1'b0, 3'd0}) begin
      errors++; $display("FAIL lat_pop got em=%b rv=%b lv=%0d exp em=1 rv=0 lv=0", em0, rv0, lv0);
    end
    // read_ready held while a new entry arrives: it must not pop before valid
    we = 1'b1; wd = 8'hD5;
    step();
    we = 1'b0;
    checks++;
    if ({rv0, lv0} !== {1'b0, 3'd1}) begin
      errors++; $display("FAIL rr_early got rv=%b lv=%0d exp rv=0 lv=1", rv0, lv0);
    end
    step();
    checks++;
    if ({rv0, rd0, lv0} !== {1'b1, 8'hD5, 3'd1}) begin
      errors++; $display("FAIL rr_noeffect got rv=%b rd=%h lv=%0d exp rv=1 rd=d5 lv=1", rv0, rd0, lv0);
    end
    step();
    checks++;
    if ({em0, em1, rv0, rv1} !== 4'b1100) begin
      errors++; $display("FAIL rr_pop got em0=%b em1=%b rv0=%b rv1=%b exp 1 1 0 0", em0, em1, rv0, rv1);
    end
    rr = 1'b0;
  endtask

  task automatic test_overflow();
    logic [7:0] exp0, exp1;
    for (int i = 1; i <= 4; i++) begin
      we = 1'b1; wd = 8'(i);
      step();
    end
    checks++;
    if ({fu0, lv0, ov0, fu1, lv1, ov1} !== {1'b1, 3'd4, 1'b0, 1'b1, 3'd4, 1'b0}) begin
      errors++; $display("FAIL fill got fu=%b/%b lv=%0d/%0d ov=%b/%b exp fu=1 lv=4 ov=0",
                         fu0, fu1, lv0, lv1, ov0, ov1);
    end
    wd = 8'h05;
    step();
    we = 1'b0;
    checks++;
    if ({ov0, oc0, lv0, rv0, rd0} !== {1'b1, 16'd1, 3'd4, 1'b1, 8'h01}) begin
      errors++; $display("FAIL drop_ovf got ov=%b oc=%0d lv=%0d rv=%b rd=%h exp ov=1 oc=1 lv=4 rv=1 rd=01",
                         ov0, oc0, lv0, rv0, rd0);
    end
    checks++;
    if ({ov1, oc1, lv1, rv1, rd1} !== {1'b1, 16'd1, 3'd4, 1'b1, 8'h02}) begin
      errors++; $display("FAIL ovwr_ovf got ov=%b oc=%0d lv=%0d rv=%b rd=%h exp ov=1 oc=1 lv=4 rv=1 rd=02",
                         ov1, oc1, lv1, rv1, rd1);
    end
    rr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp0 = 8'(i + 1);
      exp1 = 8'(i + 2);
      checks++;
      if ({rv0, rd0} !== {1'b1, exp0}) begin
        errors++; $display("FAIL drop_pop%0d got rv=%b rd=%h exp rv=1 rd=%h", i, rv0, rd0, exp0);
      end
      checks++;
      if ({rv1, rd1} !== {1'b1, exp1}) begin
        errors++; $display("FAIL ovwr_pop%0d got rv=%b rd=%h exp rv=1 rd=%h", i, rv1, rd1, exp1);
      end
      step();
    end
    rr = 1'b0;
    checks++;
    if ({em0, rv0, em1, rv1, oc0, oc1} !== {1'b1, 1'b0, 1'b1, 1'b0, 16'd1, 16'd1}) begin
      errors++; $display("FAIL drain got em=%b/%b rv=%b/%b oc=%0d/%0d exp em=1 rv=0 oc=1",
                         em0, em1, rv0, rv1, oc0, oc1);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 3; i++) begin
      we = 1'b1; wd = 8'hA1 + 8'(i);
      step();
    end
    checks++;
    if ({lv0, lv1} !== {3'd3, 3'd3}) begin
      errors++; $display("FAIL clr_fill got lv=%0d/%0d exp 3", lv0, lv1);
    end
    clear = 1'b1; we = 1'b1; wd = 8'hA4; rr = 1'b1;
    step();
    clear = 1'b0; we = 1'b0; rr = 1'b0;
    checks++;
    if ({lv0, rv0, ov0, oc0, em0} !== {3'd0, 1'b0, 1'b0, 16'd0, 1'b1}) begin
      errors++; $display("FAIL clr_drop got lv=%0d rv=%b ov=%b oc=%0d em=%b exp 0 0 0 0 1", lv0, rv0, ov0, oc0, em0);
    end
    checks++;
    if ({lv1, rv1, ov1, oc1, em1} !== {3'd0, 1'b0, 1'b0, 16'd0, 1'b1}) begin
      errors++; $display("FAIL clr_ovwr got lv=%0d rv=%b ov=%b oc=%0d em=%b exp 0 0 0 0 1", lv1, rv1, ov1, oc1, em1);
    end
    step(); step();
    checks++;
    if ({rv0, rv1, lv0, lv1} !== {1'b0, 1'b0, 3'd0, 3'd0}) begin
      errors++; $display("FAIL clr_stale got rv=%b/%b lv=%0d/%0d exp rv=0 lv=0", rv0, rv1, lv0, lv1);
    end
    we = 1'b1; wd = 8'hB1;
    step();
    we = 1'b0;
    step();
    checks++;
    if ({rv0, rd0, lv0, rv1, rd1, lv1} !== {1'b1, 8'hB1, 3'd1, 1'b1, 8'hB1, 3'd1}) begin
      errors++; $display("FAIL clr_next got rd=%h/%h lv=%0d/%0d exp rd=b1 lv=1", rd0, rd1, lv0, lv1);
    end
    rr = 1'b1;
    step();
    rr = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) begin
      we = 1'b1; wd = 8'(i);
      step();
    end
    rr = 1'b1;
    for (int c = 0; c < 20; c++) begin
      wd  = 8'(c + 4);
      exp = 8'(c);
      checks++;
      if ({lv0, fu0, rv0, ov0, rd0} !== {3'd4, 1'b1, 1'b1, 1'b0, exp}) begin
        errors++; $display("FAIL b2b_drop c=%0d got lv=%0d fu=%b rv=%b ov=%b rd=%h exp lv=4 fu=1 rv=1 ov=0 rd=%h",
                           c, lv0, fu0, rv0, ov0, rd0, exp);
      end
      checks++;
      if ({lv1, fu1, rv1, ov1, rd1} !== {3'd4, 1'b1, 1'b1, 1'b0, exp}) begin
        errors++; $display("FAIL b2b_ovwr c=%0d got lv=%0d fu=%b rv=%b ov=%b rd=%h exp lv=4 fu=1 rv=1 ov=0 rd=%h",
                           c, lv1, fu1, rv1, ov1, rd1, exp);
      end
      step();
    end
    we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp = 8'(20 + k);
      checks++;
      if ({rv0, rd0, rv1, rd1} !== {1'b1, exp, 1'b1, exp}) begin
        errors++; $display("FAIL b2b_tail%0d got rd=%h/%h rv=%b/%b exp rd=%h", k, rd0, rd1, rv0, rv1, exp);
      end
      step();
    end
    rr = 1'b0;
    checks++;
    if ({em0, em1, oc0, oc1} !== {1'b1, 1'b1, 16'd0, 16'd0}) begin
      errors++; $display("FAIL b2b_end got em=%b/%b oc=%0d/%0d exp em=1 oc=0", em0, em1, oc0, oc1);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      we = 1'b1; wd = 8'hC1 + 8'(i);
      step();
    end
    we = 1'b0;
    step();
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({rv0, em0, fu0, lv0, ov0, oc0, rd0} !== {1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 16'd0, 8'd0}) begin
      errors++; $display("FAIL arst_drop got rv=%b em=%b lv=%0d rd=%h exp rv=0 em=1 lv=0 rd=00", rv0, em0, lv0, rd0);
    end
    checks++;
    if ({rv1, em1, fu1, lv1, ov1, oc1, rd1} !== {1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 16'd0, 8'd0}) begin
      errors++; $display("FAIL arst_ovwr got rv=%b em=%b lv=%0d rd=%h exp rv=0 em=1 lv=0 rd=00", rv1, em1, lv1, rd1);
    end
    #1 reset = 1'b1;
    we = 1'b1; wd = 8'hEE;
    step();
    we = 1'b0;
    step();
    checks++;
    if ({rv0, rd0, lv0, rv1, rd1, lv1} !== {1'b1, 8'hEE, 3'd1, 1'b1, 8'hEE, 3'd1}) begin
      errors++; $display("FAIL arst_first got rd=%h/%h lv=%0d/%0d exp rd=ee lv=1", rd0, rd1, lv0, lv1);
    end
    rr = 1'b1;
    step();
    rr = 1'b0;
    checks++;
    if ({em0, em1, rv0, rv1} !== 4'b1100) begin
      errors++; $display("FAIL arst_drain got em=%b/%b rv=%b/%b exp em=1 rv=0", em0, em1, rv0, rv1);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_overflow();
    test_clear();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ring_buffer.md
RING_BUFFER -- requirements
Module: ring_buffer

Interface
REQ-001 Parameter DW, default 8, data width in bits.
REQ-002 Parameter AW, default 8, address width; capacity DEPTH = 2^AW entries.
REQ-003 Parameter OVERWRITE, default 0; 0 = drop new data when full, 1 = discard oldest entry when full.
REQ-004 clock  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 clear  in  1  synchronous flush of contents and overflow state.
REQ-007 write_enable  in  1  push write_data this cycle.
REQ-008 write_data  in  DW  data to push.
REQ-009 read_ready  in  1  consumer accepts read_data this cycle.
REQ-010 read_valid  out  1  read_data holds the oldest unread entry.
REQ-011 read_data  out  DW  oldest unread entry, registered.
REQ-012 empty  out  1  level == 0.
REQ-013 full  out  1  level == DEPTH.
REQ-014 level  out  AW+1  unread entries, including the one presented on read_data.
REQ-015 overflow  out  1  sticky; set on any full-condition write that loses data.
REQ-016 overflow_count  out  16  count of lost entries, saturating at 16'hFFFF.

Function
REQ-017 The block SHALL be a FIFO; entries leave in write order.
REQ-018 Pop SHALL occur on a rising edge where read_valid && read_ready; read_ready with read_valid low SHALL have no effect.
REQ-019 Push SHALL occur on a rising edge where write_enable is high, subject to REQ-022..REQ-024.
REQ-020 Latency: write accepted at edge N into an empty buffer -> read_valid = 1 with that data after edge N+1; no same-cycle bypass.
REQ-021 After a pop with further entries stored, read_valid SHALL stay high and read_data SHALL show the next entry after that same edge (back-to-back throughput of one entry per cycle).
REQ-022 Push and pop on the same edge SHALL both take effect; level unchanged; no overflow, including when full.
REQ-023 OVERWRITE=0, full, push without pop: write_data SHALL be discarded; contents, level unchanged; overflow set; overflow_count += 1.
REQ-024 OVERWRITE=1, full, push without pop: oldest entry SHALL be discarded, write_data stored; level stays DEPTH; read_data shows the next oldest after the edge; overflow set; overflow_count += 1.
REQ-025 overflow_count SHALL saturate at 16'hFFFF and not wrap.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH with no gap or duplication across wrap.
REQ-027 level SHALL be exact at every cycle: +1 on push-only, -1 on pop-only, unchanged otherwise or on dropped push.
REQ-028 clear SHALL, at the next edge, set level 0, read_valid 0, overflow 0, overflow_count 0; clear SHALL override a same-cycle push and pop.
REQ-029 Memory contents SHALL NOT need reset; only pointers, level, flags, counter and read_valid are reset.

Reset
REQ-030 reset low SHALL immediately (asynchronously) force read_valid 0, empty 1, full 0, level 0, overflow 0, overflow_count 0, read_data 0.
REQ-031 reset asserted mid-operation SHALL discard all stored entries; no entry written before reset SHALL appear afterwards.
REQ-032 Release of reset SHALL be usable at any clock phase; first push accepted at the first rising edge with reset high.

Verification
REQ-033 Reset, then push 8'hF1 at edge N, read_ready 0 -> read_valid 1, read_data 8'hF1, level 1 after edge N+1; stays until popped.
REQ-034 AW=2, push 8'h01..8'h04 -> full 1, level 4; push 8'h05 (OVERWRITE=0) -> overflow 1, count 1; pops yield 01,02,03,04 then empty 1.
REQ-035 Same with OVERWRITE=1 -> pops yield 02,03,04,05; overflow_count 1.
REQ-036 AW=2, full, continuous push and pop for 20 cycles with incrementing data -> level constant 4, no overflow, output sequence gap-free across pointer wraps.
REQ-037 Fill to 3 entries, assert clear together with write_enable -> level 0, read_valid 0, overflow_count 0 after edge; stale data never appears.
REQ-038 Mid-stream reset low for less than one clock period -> all outputs at reset values while low; next push 8'hEE is the first entry popped.
